// File: rtl/jvm_pkg.sv
// jvm_pkg: shared widths, opcode constants, FSM state type and length-mask helper for the bytecode decoder.
package jvm_pkg;
  localparam int BYTE_WIDTH   = 8;
  localparam int WIDTH_IN     = 4 * BYTE_WIDTH;
  localparam int WIDTH_OUT    = 4 * BYTE_WIDTH;
  localparam int ADDRESS_SIZE = 16;
  localparam logic [7:0] ICONST_0       = 8'h03;
  localparam logic [7:0] BIPUSH         = 8'h10;
  localparam logic [7:0] SIPUSH         = 8'h11;
  localparam logic [7:0] LDC            = 8'h12;
  localparam logic [7:0] LASTORE        = 8'h50;
  localparam logic [7:0] DDIV           = 8'h6F;
  localparam logic [7:0] IINC           = 8'h84;
  localparam logic [7:0] I2B            = 8'h91;
  localparam logic [7:0] RET            = 8'hA9;
  localparam logic [7:0] NEWARRAY       = 8'hBC;
  localparam logic [7:0] MULTIANEWARRAY = 8'hC5;
  typedef enum logic {IDLE, DECODE} state_t;
  // Keeps the opcode plus len-1 operand bytes, left-aligned.
  function automatic logic [WIDTH_OUT-1:0] len_mask(input logic [2:0] len);
    return len == 3'd4 ? 32'hFFFF_FFFF :
           len == 3'd3 ? 32'hFFFF_FF00 :
           len == 3'd2 ? 32'hFFFF_0000 : 32'hFF00_0000;
  endfunction
endpackage

// File: rtl/jvm_opcode_length.sv
// jvm_opcode_length: combinational opcode -> instruction length (1..4 bytes).
// Unsupported opcodes fall through to length 1.
module jvm_opcode_length
  import jvm_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [2:0] len_o
);
  always_comb begin
    len_o = 3'd1;
    case (opcode_i) inside
      BIPUSH, LDC, [8'h15:8'h19], [8'h36:8'h3A], RET, NEWARRAY: len_o = 3'd2;
      SIPUSH, 8'h13, 8'h14, IINC, [8'h99:8'hA8], [8'hB2:8'hB8],
      8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:                 len_o = 3'd3;
      MULTIANEWARRAY:                                            len_o = 3'd4;
      default:                                                   len_o = 3'd1;
    endcase
  end
endmodule

// File: rtl/jvm_bytecode_decoder.sv
// jvm_bytecode_decoder: two-cycle accept/decode FSM that trims each instruction to its length,
// advances the pc and strobes a fetch of the next instruction address.
module jvm_bytecode_decoder
  import jvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH_IN-1:0]     instruction_in,
  output logic                    ready,
  output logic [WIDTH_OUT-1:0]    instruction_out,
  output logic                    start_for_memory,
  output logic [ADDRESS_SIZE-1:0] address_for_memory
);
  state_t                  state_q, state_d;
  logic [WIDTH_IN-1:0]     instr_q, instr_d;
  logic [WIDTH_OUT-1:0]    out_q, out_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d, addr_q, addr_d;
  logic                    ready_q, ready_d, fetch_q, fetch_d;
  logic [2:0]              len;

  jvm_opcode_length u_len (
    .opcode_i (instr_q[WIDTH_IN-1 -: BYTE_WIDTH]),
    .len_o    (len)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    out_d   = out_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ready_d = 1'b0;
    fetch_d = 1'b0;
    if (state_q == IDLE && start) begin
      instr_d = instruction_in;
      state_d = DECODE;
    end else if (state_q == DECODE) begin
      out_d   = instr_q & len_mask(len);
      pc_d    = pc_q + {{(ADDRESS_SIZE-3){1'b0}}, len};
      addr_d  = pc_d;
      ready_d = 1'b1;
      fetch_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      out_q   <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      fetch_q <= fetch_d;
    end
  end

  assign ready              = ready_q;
  assign start_for_memory   = fetch_q;
  assign instruction_out    = out_q;
  assign address_for_memory = addr_q;
endmodule

// File: tb/tb_jvm_bytecode_decoder.sv
// tb_jvm_bytecode_decoder: directed-vector bench with immediate assertions for jvm_bytecode_decoder.
module tb_jvm_bytecode_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction_in = '0;
  logic        ready;
  logic [31:0] instruction_out;
  logic        start_for_memory;
  logic [15:0] address_for_memory;
  int          tests = 0;
  int          fails = 0;

  jvm_bytecode_decoder dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .instruction_in     (instruction_in),
    .ready              (ready),
    .instruction_out    (instruction_out),
    .start_for_memory   (start_for_memory),
    .address_for_memory (address_for_memory)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM in IDLE; returns at the negedge after the result edge.
  task automatic decode(input string tag, input logic [31:0] word,
                        input logic [31:0] exp_out, input logic [15:0] exp_addr);
    instruction_in = word;
    start = 1'b1;
    @(negedge clk);
    chk({tag, ".ready_mid"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, ready}, 32'd1);
    chk({tag, ".fetch"}, {31'b0, start_for_memory}, 32'd1);
    chk({tag, ".out"}, instruction_out, exp_out);
    chk({tag, ".addr"}, {16'b0, address_for_memory}, {16'b0, exp_addr});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.out", instruction_out, 32'd0);
    chk("rst.addr", {16'b0, address_for_memory}, 32'd0);
    chk("rst.ready", {31'b0, ready}, 32'd0);
    chk("rst.fetch", {31'b0, start_for_memory}, 32'd0);
    reset = 1'b1;
    decode("iconst_0", 32'h0300_0000, 32'h0300_0000, 16'h0001);
    decode("iconst_1", 32'h0400_0000, 32'h0400_0000, 16'h0002);
    decode("ddiv",     32'h6F00_0000, 32'h6F00_0000, 16'h0003);
    decode("i2b",      32'h9100_0000, 32'h9100_0000, 16'h0004);
    decode("lastore",  32'h5000_0000, 32'h5000_0000, 16'h0005);
    decode("bipush",   32'h10AB_1234, 32'h10AB_0000, 16'h0007);
    decode("sipush",   32'h1112_34FF, 32'h1112_3400, 16'h000A);
    decode("multianew",32'hC512_3402, 32'hC512_3402, 16'h000E);
    decode("unsup_d0", 32'hD0FF_FFFF, 32'hD000_0000, 16'h000F);
    decode("unsup_aa", 32'hAAFF_FFFF, 32'hAA00_0000, 16'h0010);
    decode("jsr",      32'hA812_3456, 32'hA812_3400, 16'h0013);
    decode("iload",    32'h1577_8899, 32'h1577_0000, 16'h0015);
    start = 1'b0;
    @(negedge clk);
    chk("idle.ready", {31'b0, ready}, 32'd0);
    chk("idle.fetch", {31'b0, start_for_memory}, 32'd0);
    chk("idle.hold_out", instruction_out, 32'h1577_0000);
    chk("idle.hold_addr", {16'b0, address_for_memory}, 32'h0000_0015);
    // Abort a decode by asserting reset inside the DECODE cycle.
    instruction_in = 32'h10AA_BBCC;
    start = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort.ready", {31'b0, ready}, 32'd0);
    chk("abort.out", instruction_out, 32'd0);
    chk("abort.addr", {16'b0, address_for_memory}, 32'd0);
    @(negedge clk);
    chk("abort.no_pulse", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    decode("after_abort", 32'h11AA_BBCC, 32'h11AA_BB00, 16'h0003);
    // Fresh pc, then walk to 0xFFFF with 4-byte and 1-byte decodes.
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    instruction_in = 32'hC500_0000;
    start = 1'b1;
    for (int i = 0; i < 16383; i++) repeat (2) @(negedge clk);
    chk("walk.addr", {16'b0, address_for_memory}, 32'h0000_FFFC);
    decode("nop_fffd", 32'h0000_0000, 32'h0000_0000, 16'hFFFD);
    decode("nop_fffe", 32'h0000_0000, 32'h0000_0000, 16'hFFFE);
    decode("nop_ffff", 32'h0000_0000, 32'h0000_0000, 16'hFFFF);
    decode("wrap",     32'h1000_0000, 32'h1000_0000, 16'h0001);
    start = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
